// File: rtl/capture_ctrl_pkg.sv
// Shared definitions for the capture controller, its MCU interface and the trigger block.
package capture_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic logic st_capturing(input state_e st);
    return (st == ST_PREFILL) || (st == ST_ARMED) || (st == ST_POST);
  endfunction

  function automatic logic st_trig_enabled(input state_e st);
    return (st == ST_ARMED) || (st == ST_POST);
  endfunction

endpackage

// File: rtl/capture_ctrl_addr_cnt.sv
// Wrapping ADDR_W-bit address counter with synchronous load and increment.
module capture_ctrl_addr_cnt #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] cnt
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Load wins over increment; increment wraps naturally at 2**ADDR_W.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/capture_ctrl.sv
// Sample-memory capture controller: pre-trigger fill, arming, post-trigger fill, ordered readout.
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLK_EN,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Force_Trig,
  input  logic [ADDR_W-1:0] Pretrig_Len,
  input  logic [ADDR_W-1:0] Post_Len,
  input  logic              trig_in,
  input  logic              RD_Start,
  input  logic              RD_Next,
  output logic              Start_Write,
  output logic              Enable_Trig,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic [ADDR_W-1:0] Trig_Addr,
  output logic              Busy,
  output logic              Done
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pre_len_q, pre_len_d;
  logic [ADDR_W-1:0] post_len_q, post_len_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              trig_pend_q, trig_pend_d;
  logic              start_write_q, start_write_d;
  logic              enable_trig_q, enable_trig_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              wr_load, wr_inc, rd_load, rd_inc;
  logic              trig_req;
  logic [ADDR_W-1:0] rd_load_val;

  assign trig_req    = trig_in | Force_Trig;
  assign rd_load_val = trig_addr_q - pre_len_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pre_len_d   = pre_len_q;
    post_len_d  = post_len_q;
    trig_addr_d = trig_addr_q;
    trig_pend_d = trig_pend_q;
    wr_load     = 1'b0;
    wr_inc      = 1'b0;
    rd_load     = 1'b0;
    rd_inc      = 1'b0;

    if (Stop) begin
      state_d     = ST_IDLE;
      trig_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            pre_len_d   = Pretrig_Len;
            post_len_d  = Post_Len;
            cnt_d       = Pretrig_Len;
            trig_pend_d = 1'b0;
            wr_load     = 1'b1;
            state_d     = (Pretrig_Len == '0) ? ST_ARMED : ST_PREFILL;
          end else if (state_q == ST_DONE) begin
            rd_load = RD_Start;
            rd_inc  = RD_Next & ~RD_Start;
          end
        end
        ST_PREFILL: begin
          if (CLK_EN) begin
            wr_inc = 1'b1;
            cnt_d  = cnt_q - ONE;
            if (cnt_q == ONE) begin
              state_d = ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          // A trigger seen between strobes stays pending so the next strobe becomes the trigger sample.
          if (CLK_EN) begin
            wr_inc = 1'b1;
            if (trig_req || trig_pend_q) begin
              trig_addr_d = WR_ADDR;
              trig_pend_d = 1'b0;
              cnt_d       = post_len_q - ONE;
              state_d     = (post_len_q <= ONE) ? ST_DONE : ST_POST;
            end
          end else if (trig_req) begin
            trig_pend_d = 1'b1;
          end
        end
        ST_POST: begin
          if (CLK_EN) begin
            wr_inc = 1'b1;
            cnt_d  = cnt_q - ONE;
            if (cnt_q == ONE) begin
              state_d = ST_DONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    start_write_d = st_capturing(state_d);
    busy_d        = st_capturing(state_d);
    enable_trig_d = st_trig_enabled(state_d);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      pre_len_q     <= '0;
      post_len_q    <= '0;
      trig_addr_q   <= '0;
      trig_pend_q   <= 1'b0;
      start_write_q <= 1'b0;
      enable_trig_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pre_len_q     <= pre_len_d;
      post_len_q    <= post_len_d;
      trig_addr_q   <= trig_addr_d;
      trig_pend_q   <= trig_pend_d;
      start_write_q <= start_write_d;
      enable_trig_q <= enable_trig_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  capture_ctrl_addr_cnt #(.ADDR_W(ADDR_W)) u_wr_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (wr_load),
    .inc      (wr_inc),
    .load_val ('0),
    .cnt      (WR_ADDR)
  );

  capture_ctrl_addr_cnt #(.ADDR_W(ADDR_W)) u_rd_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (rd_load),
    .inc      (rd_inc),
    .load_val (rd_load_val),
    .cnt      (RD_ADDR)
  );

  assign Start_Write = start_write_q;
  assign Enable_Trig = enable_trig_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Trig_Addr   = trig_addr_q;
  assign WR_EN       = CLK_EN & busy_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: write-count model checked every cycle plus directed literal checks.
module tb_capture_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CLK_EN = 1'b0, Start = 1'b0, Stop = 1'b0, Force_Trig = 1'b0;
  logic          trig_in = 1'b0, RD_Start = 1'b0, RD_Next = 1'b0;
  logic [AW-1:0] Pretrig_Len = '0, Post_Len = '0;
  logic          Start_Write, Enable_Trig, WR_EN, Busy, Done;
  logic [AW-1:0] WR_ADDR, RD_ADDR, Trig_Addr;

  int n_cmp = 0;
  int n_err = 0;

  capture_ctrl #(.ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .CLK_EN(CLK_EN), .Start(Start), .Stop(Stop),
    .Force_Trig(Force_Trig), .Pretrig_Len(Pretrig_Len), .Post_Len(Post_Len),
    .trig_in(trig_in), .RD_Start(RD_Start), .RD_Next(RD_Next),
    .Start_Write(Start_Write), .Enable_Trig(Enable_Trig), .WR_EN(WR_EN),
    .WR_ADDR(WR_ADDR), .RD_ADDR(RD_ADDR), .Trig_Addr(Trig_Addr),
    .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Model: mode 0 idle / 1 capturing / 2 done; m_wr counts writes since Start.
  int m_mode = 0, m_wr = 0, m_pre = 0, m_post = 1, m_trig_idx = -1, m_taddr = 0, m_rd = 0;
  bit m_pend = 0, m_armed, m_want, m_cap;

  initial forever begin
    @(posedge CLK);
    if (RST) begin
      m_mode = 0; m_wr = 0; m_pre = 0; m_post = 1; m_trig_idx = -1;
      m_taddr = 0; m_rd = 0; m_pend = 0;
    end else if (Stop) begin
      m_mode = 0; m_pend = 0;
    end else if (m_mode != 1) begin
      if (Start) begin
        m_mode = 1; m_wr = 0; m_pre = int'(Pretrig_Len);
        m_post = (Post_Len == 0) ? 1 : int'(Post_Len);
        m_trig_idx = -1; m_pend = 0;
      end else if (m_mode == 2) begin
        if (RD_Start) m_rd = ((m_taddr - m_pre) % DEPTH + DEPTH) % DEPTH;
        else if (RD_Next) m_rd = (m_rd + 1) % DEPTH;
      end
    end else begin
      m_armed = (m_wr >= m_pre);
      m_want  = trig_in | Force_Trig;
      if (CLK_EN) begin
        if (m_armed && m_trig_idx < 0 && (m_want || m_pend)) begin
          m_trig_idx = m_wr; m_taddr = m_wr % DEPTH; m_pend = 0;
        end
        m_wr++;
        if (m_trig_idx >= 0 && (m_wr - m_trig_idx) >= m_post) m_mode = 2;
      end else if (m_armed && m_trig_idx < 0 && m_want) begin
        m_pend = 1;
      end
    end
    #1;
    m_cap = (m_mode == 1);
    chk("busy",        int'(Busy),        int'(m_cap));
    chk("start_write", int'(Start_Write), int'(m_cap));
    chk("enable_trig", int'(Enable_Trig), int'(m_cap && (m_wr >= m_pre)));
    chk("done",        int'(Done),        int'(m_mode == 2));
    chk("wr_en",       int'(WR_EN),       int'(CLK_EN && m_cap));
    chk("wr_addr",     int'(WR_ADDR),     m_wr % DEPTH);
    chk("trig_addr",   int'(Trig_Addr),   m_taddr);
    chk("rd_addr",     int'(RD_ADDR),     m_rd);
  end

  task automatic start_cap(input int pre, input int post);
    Pretrig_Len = AW'(pre);
    Post_Len    = AW'(post);
    CLK_EN      = 1'b0;
    Start       = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  // n cycles, strobe every 'period' cycles, trig_in high for cycle indices t0..t1
  task automatic run(input int n, input int period, input int t0, input int t1);
    for (int i = 0; i < n; i++) begin
      CLK_EN  = ((i % period) == 0);
      trig_in = (i >= t0) && (i <= t1);
      @(negedge CLK);
    end
    CLK_EN  = 1'b0;
    trig_in = 1'b0;
  endtask

  task automatic rd_ops(input bit do_start, input int n_next);
    if (do_start) begin
      RD_Start = 1'b1;
      @(negedge CLK);
      RD_Start = 1'b0;
    end
    for (int i = 0; i < n_next; i++) begin
      RD_Next = 1'b1;
      @(negedge CLK);
    end
    RD_Next = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_busy", int'(Busy), 0);
    chk("reset_wr_addr", int'(WR_ADDR), 0);
    RST = 1'b0;
    @(negedge CLK);

    // 1: basic capture, trigger on 10th armed cycle
    start_cap(3, 4);
    run(20, 1, 12, 12);
    chk("t1_done", int'(Done), 1);
    chk("t1_trig_addr", int'(Trig_Addr), 12);
    rd_ops(1'b1, 0);
    chk("t1_rd_start", int'(RD_ADDR), 9);
    rd_ops(1'b0, 7);
    chk("t1_rd_wrap", int'(RD_ADDR), 0);

    // 2: zero lengths, forced trigger
    Force_Trig = 1'b1;
    start_cap(0, 0);
    chk("t2_armed_next", int'(Enable_Trig), 1);
    CLK_EN = 1'b1;
    @(negedge CLK);
    CLK_EN = 1'b0;
    Force_Trig = 1'b0;
    chk("t2_done", int'(Done), 1);
    chk("t2_trig_addr", int'(Trig_Addr), 0);
    chk("t2_wr_addr", int'(WR_ADDR), 1);
    rd_ops(1'b1, 0);
    chk("t2_rd_start", int'(RD_ADDR), 0);

    // 3: sparse strobes, trigger between strobes
    start_cap(2, 2);
    run(18, 3, 10, 10);
    chk("t3_done", int'(Done), 1);
    chk("t3_trig_addr", int'(Trig_Addr), 4);
    rd_ops(1'b1, 0);
    chk("t3_rd_start", int'(RD_ADDR), 2);

    // 4: trigger held high through prefill
    start_cap(5, 3);
    run(12, 1, 0, 11);
    chk("t4_done", int'(Done), 1);
    chk("t4_trig_addr", int'(Trig_Addr), 5);
    rd_ops(1'b1, 2);
    chk("t4_rd_next", int'(RD_ADDR), 2);

    // 5: Stop during post, with simultaneous Start
    start_cap(1, 8);
    run(4, 1, 1, 1);
    chk("t5_in_post", int'(Busy), 1);
    Stop = 1'b1; Start = 1'b1; CLK_EN = 1'b1;
    @(negedge CLK);
    chk("t5_busy", int'(Busy), 0);
    chk("t5_wr_en", int'(WR_EN), 0);
    chk("t5_start_write", int'(Start_Write), 0);
    chk("t5_enable_trig", int'(Enable_Trig), 0);
    Stop = 1'b0; Start = 1'b0; CLK_EN = 1'b0;
    @(negedge CLK);
    chk("t5_stays_idle", int'(Busy), 0);

    // 6: reset while armed, then clean capture
    start_cap(2, 3);
    run(4, 1, -1, -1);
    chk("t6_armed", int'(Enable_Trig), 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("t6_rst_busy", int'(Busy), 0);
    chk("t6_rst_wr_addr", int'(WR_ADDR), 0);
    chk("t6_rst_trig_addr", int'(Trig_Addr), 0);
    start_cap(2, 2);
    run(8, 1, 3, 3);
    chk("t6_done", int'(Done), 1);
    chk("t6_trig_addr", int'(Trig_Addr), 3);
    rd_ops(1'b1, 0);
    chk("t6_rd_start", int'(RD_ADDR), 1);

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
